// File: rtl/arb_2t_wrr_if.sv
// Bus bundle for the two-tier weighted round-robin arbiter.
//   master : requester side, drives enable/request/prior/quota/lock/mask, observes grant status
//   slave  : arbiter side, samples the request bundle, drives parked/granted/locked/grant/index
// Fields of prior and quota are packed per requester: field i = vec[i*W +: W].
interface arb_2t_wrr_if #(
  parameter int unsigned N       = 4,
  parameter int unsigned P_WIDTH = 2,
  parameter int unsigned Q_WIDTH = 3,
  parameter int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1
);
  logic                   enable;
  logic [N-1:0]           request;
  logic [P_WIDTH*N-1:0]   prior;
  logic [Q_WIDTH*N-1:0]   quota;
  logic [N-1:0]           lock;
  logic [N-1:0]           mask;
  logic                   parked;
  logic                   granted;
  logic                   locked;
  logic [N-1:0]           grant;
  logic [IDX_W-1:0]       grant_index;

  modport master (
    output enable, request, prior, quota, lock, mask,
    input  parked, granted, locked, grant, grant_index
  );

  modport slave (
    input  enable, request, prior, quota, lock, mask,
    output parked, granted, locked, grant, grant_index
  );
endinterface

// File: rtl/arb_2t_wrr.sv
// Two-tier arbiter for N requesters: tier 1 picks the highest effective priority, tier 2 breaks
// ties round-robin starting after the last winner. The grantee may hold the grant for up to
// max(quota,1) consecutive cycles, or indefinitely while it asserts lock. Masked requesters are
// never eligible. When nobody is eligible the grant parks on PARK_INDEX (PARK_MODE=1) or is zero.
// All outputs are registered: inputs sampled on one edge show up after that edge.
//
// Ports
//   clk   : clock, all state on the rising edge
//   rst   : synchronous active-high reset
//   init  : synchronous active-high soft clear, same effect as rst
//   bus   : arb_2t_wrr_if.slave (enable, request, prior, quota, lock, mask in;
//           parked, granted, locked, grant, grant_index out)
//
// Configuration macro ARB_2T_AGE_EN: when defined, each requester has an 8-bit saturating wait
// counter; once it reaches AGE_LIMIT the requester competes at the top priority level, which
// bounds the wait of any non-locked requester. When undefined there is no ageing.
module arb_2t_wrr #(
  parameter int unsigned N          = 4,
  parameter int unsigned P_WIDTH    = 2,
  parameter int unsigned Q_WIDTH    = 3,
  parameter int unsigned PARK_MODE  = 1,
  parameter int unsigned PARK_INDEX = 0,
  parameter int unsigned AGE_LIMIT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  arb_2t_wrr_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N);

  localparam logic [N-1:0]     ParkGrant = (PARK_MODE != 0) ? (N'(1) << PARK_INDEX) : {N{1'b0}};
  localparam logic [IDX_W-1:0] ParkIdx   = (PARK_MODE != 0) ? IDX_W'(PARK_INDEX) : {IDX_W{1'b0}};
  localparam logic             ParkFlag  = (PARK_MODE != 0);

  if (N < 2 || N > 32 || PARK_INDEX >= N || AGE_LIMIT < 1 || AGE_LIMIT > 255 ||
      P_WIDTH < 1 || Q_WIDTH < 1) begin : g_bad_param
    $error("arb_2t_wrr: illegal parameter value");
  end

  logic [N-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               parked_q, parked_d;
  logic               granted_q, granted_d;
  logic               locked_q, locked_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [Q_WIDTH-1:0] burst_q, burst_d;

  logic [N-1:0]       elig;
  logic [P_WIDTH-1:0] eff_pri [N];

  assign elig = bus.request & ~bus.mask;

`ifdef ARB_2T_AGE_EN
  logic [7:0] age_q [N];
  logic [7:0] age_d [N];

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      eff_pri[i] = (age_q[i] >= 8'(AGE_LIMIT)) ? {P_WIDTH{1'b1}}
                                                : bus.prior[i*P_WIDTH +: P_WIDTH];
    end
  end

  // Only a real grant resets the wait; the park grant does not count as service.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      age_d[i] = age_q[i];
      if (bus.enable) begin
        if (elig[i] && !(grant_q[i] && granted_q)) begin
          age_d[i] = (age_q[i] == 8'hFF) ? age_q[i] : age_q[i] + 8'd1;
        end else begin
          age_d[i] = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (rst || init) begin
        age_q[i] <= 8'd0;
      end else begin
        age_q[i] <= age_d[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      eff_pri[i] = bus.prior[i*P_WIDTH +: P_WIDTH];
    end
  end
`endif

  // Scan from the requester after the round-robin pointer; strict '>' keeps the first of equals.
  logic               win_found;
  logic [P_WIDTH-1:0] win_pri;
  logic [IDX_W-1:0]   win_idx;

  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_pri   = '0;
    win_idx   = '0;
    for (int k = 1; k <= int'(N); k++) begin
      j = int'(rr_q) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (elig[j] && (!win_found || eff_pri[j] > win_pri)) begin
        win_found = 1'b1;
        win_pri   = eff_pri[j];
        win_idx   = IDX_W'(j);
      end
    end
  end

  logic               g_elig;
  logic               g_lock;
  logic [Q_WIDTH-1:0] q_raw;
  logic [Q_WIDTH-1:0] q_eff;
  logic [Q_WIDTH:0]   burst_inc;

  assign g_elig    = granted_q & elig[idx_q];
  assign g_lock    = bus.lock[idx_q];
  assign q_raw     = bus.quota[int'(idx_q)*Q_WIDTH +: Q_WIDTH];
  assign q_eff     = (q_raw == '0) ? Q_WIDTH'(1) : q_raw;
  assign burst_inc = {1'b0, burst_q} + (Q_WIDTH+1)'(1);

  always_comb begin
    grant_d   = ParkGrant;
    idx_d     = ParkIdx;
    parked_d  = ParkFlag;
    granted_d = 1'b0;
    locked_d  = 1'b0;
    rr_d      = rr_q;
    burst_d   = '0;
    if (bus.enable) begin
      if (g_elig && g_lock) begin
        grant_d   = grant_q;
        idx_d     = idx_q;
        parked_d  = 1'b0;
        granted_d = 1'b1;
        locked_d  = 1'b1;
        // Saturate so a released lock falls straight through to arbitration.
        burst_d   = (burst_q < q_eff) ? burst_q + Q_WIDTH'(1) : burst_q;
      end else if (g_elig && (burst_inc < {1'b0, q_eff})) begin
        grant_d   = grant_q;
        idx_d     = idx_q;
        parked_d  = 1'b0;
        granted_d = 1'b1;
        burst_d   = burst_inc[Q_WIDTH-1:0];
      end else if (win_found) begin
        grant_d   = N'(1) << win_idx;
        idx_d     = win_idx;
        parked_d  = 1'b0;
        granted_d = 1'b1;
        rr_d      = win_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      grant_q   <= ParkGrant;
      idx_q     <= ParkIdx;
      parked_q  <= ParkFlag;
      granted_q <= 1'b0;
      locked_q  <= 1'b0;
      rr_q      <= IDX_W'(N - 1);
      burst_q   <= '0;
    end else begin
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      parked_q  <= parked_d;
      granted_q <= granted_d;
      locked_q  <= locked_d;
      rr_q      <= rr_d;
      burst_q   <= burst_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_index = idx_q;
  assign bus.parked      = parked_q;
  assign bus.granted     = granted_q;
  assign bus.locked      = locked_q;
endmodule

// File: tb/tb_arb_2t_wrr.sv
module tb_arb_2t_wrr;
  localparam int unsigned N  = 4;
  localparam int unsigned PW = 2;
  localparam int unsigned QW = 3;

  logic clk = 1'b0;
  logic rst;
  logic init;

  always #5 clk = ~clk;

  arb_2t_wrr_if #(.N(N), .P_WIDTH(PW), .Q_WIDTH(QW)) bus ();

  arb_2t_wrr #(
    .N(N), .P_WIDTH(PW), .Q_WIDTH(QW),
    .PARK_MODE(1), .PARK_INDEX(0), .AGE_LIMIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .init(init),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0] g;
    logic [1:0] ix;
    logic       pk;
    logic       gr;
    logic       lk;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   age_seq [8];

  // Monitor: one expected entry per edge, checked just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        if (bus.grant !== e.g || bus.grant_index !== e.ix || bus.parked !== e.pk ||
            bus.granted !== e.gr || bus.locked !== e.lk) begin
          n_fail++;
          $display("FAIL %s: got grant=%b idx=%0d parked=%b granted=%b locked=%b, expected grant=%b idx=%0d parked=%b granted=%b locked=%b",
                   e.nm, bus.grant, bus.grant_index, bus.parked, bus.granted, bus.locked,
                   e.g, e.ix, e.pk, e.gr, e.lk);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic en, input logic [3:0] rq, input logic [7:0] pr,
                       input logic [11:0] qt, input logic [3:0] lk, input logic [3:0] mk);
    bus.enable  = en;
    bus.request = rq;
    bus.prior   = pr;
    bus.quota   = qt;
    bus.lock    = lk;
    bus.mask    = mk;
  endtask

  task automatic exp_grant(input int idx, input logic lkd, input string nm);
    exp_t e;
    e.g  = 4'b0001 << idx;
    e.ix = 2'(idx);
    e.pk = 1'b0;
    e.gr = 1'b1;
    e.lk = lkd;
    e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic exp_idle(input string nm);
    exp_t e;
    e.g  = 4'b0001;
    e.ix = 2'd0;
    e.pk = 1'b1;
    e.gr = 1'b0;
    e.lk = 1'b0;
    e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    int rr_seq [9];
    rr_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
`ifdef ARB_2T_AGE_EN
    age_seq = '{3, 3, 3, 3, 1, 3, 3, 3};
`else
    age_seq = '{3, 3, 3, 3, 3, 3, 3, 3};
`endif

    // Reset held with requests pending.
    rst  = 1'b1;
    init = 1'b0;
    drive(1'b1, 4'b1111, 8'h55, 12'h492, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) exp_idle("reset");
    rst = 1'b0;

    // Equal priority, quota 2: two cycles each, round-robin.
    for (int i = 0; i < 9; i++) exp_grant(rr_seq[i], 1'b0, "rr_quota2");
    exp_grant(0, 1'b0, "rr_hold");

    // Enable drop mid-burst, then resume after last winner.
    drive(1'b0, 4'b1111, 8'h55, 12'h492, 4'b0000, 4'b0000);
    exp_idle("enable_off");
    drive(1'b1, 4'b1111, 8'h55, 12'h492, 4'b0000, 4'b0000);
    exp_grant(1, 1'b0, "enable_resume");
    exp_grant(1, 1'b0, "enable_resume_hold");

    // Soft clear.
    init = 1'b1;
    exp_idle("init");
    init = 1'b0;

    // Priority tier: req2 prio 3 beats req1 prio 1 every cycle.
    drive(1'b1, 4'b0110, 8'h34, 12'h249, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) exp_grant(2, 1'b0, "prio_win");
    drive(1'b1, 4'b0010, 8'h34, 12'h249, 4'b0000, 4'b0000);
    exp_grant(1, 1'b0, "prio_fallback");
    drive(1'b1, 4'b0000, 8'h34, 12'h249, 4'b0000, 4'b0000);
    exp_idle("idle_park");

    // Lock holds against a higher priority requester.
    drive(1'b1, 4'b0001, 8'h00, 12'h249, 4'b0000, 4'b0000);
    exp_grant(0, 1'b0, "lock_pre");
    drive(1'b1, 4'b1001, 8'hC0, 12'h249, 4'b0001, 4'b0000);
    exp_grant(0, 1'b1, "lock_hold");
    exp_grant(0, 1'b1, "lock_hold2");
    drive(1'b1, 4'b1001, 8'hC0, 12'h249, 4'b0000, 4'b0000);
    exp_grant(3, 1'b0, "lock_release");

    // Mask revokes a locked grant.
    drive(1'b1, 4'b1001, 8'h03, 12'h249, 4'b0000, 4'b0000);
    exp_grant(0, 1'b0, "mask_pre");
    drive(1'b1, 4'b1001, 8'h03, 12'h249, 4'b0001, 4'b0000);
    exp_grant(0, 1'b1, "mask_lock");
    drive(1'b1, 4'b1001, 8'h03, 12'h249, 4'b0001, 4'b0001);
    exp_grant(3, 1'b0, "mask_revoke");

    // Reset wins mid-lock.
    drive(1'b1, 4'b1001, 8'h03, 12'h249, 4'b0001, 4'b0000);
    exp_grant(0, 1'b0, "relock_arb");
    exp_grant(0, 1'b1, "relock");
    rst = 1'b1;
    exp_idle("reset_mid_lock");
    rst = 1'b0;

    // Starvation / ageing: req3 prio 3 against req1 prio 0.
    drive(1'b1, 4'b1010, 8'hC0, 12'h249, 4'b0000, 4'b0000);
    for (int i = 0; i < 8; i++) exp_grant(age_seq[i], 1'b0, "age");

    drive(1'b1, 4'b0000, 8'h00, 12'h249, 4'b0000, 4'b0000);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
